// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave SRAM: word array with byte strobes, independent read/write FSMs,
// fixed or LFSR-driven response latency to stress master handshakes.
module axi_lite_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LAT_MODE    = 1,
    parameter int          FIXED_LAT   = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter logic [7:0]  LAT_MASK    = 8'h07
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);
    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    r_state_t   r_state;
    w_state_t   w_state;
    logic [7:0] lfsr;
    logic [7:0] lat;
    logic [7:0] r_cnt, w_cnt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] r_addr_q, r_addr_eff, r_off;
    logic        r_hit, r_load;
    logic [IDX_W-1:0] r_idx;

    logic        aw_got, w_got, aw_fire, w_fire, have_aw, have_w;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] w_addr_eff, w_data_eff, w_off;
    logic [3:0]  w_strb_eff;
    logic        w_hit, w_commit;
    logic [IDX_W-1:0] w_idx;

    // Both channels read the same lfsr value, so simultaneous starts share a latency.
    assign lat = (LAT_MODE != 0) ? (lfsr & LAT_MASK) : 8'(FIXED_LAT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr <= LFSR_SEED;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latches are inferred.
        r_addr_eff = (r_state == R_IDLE) ? araddr_i : r_addr_q;
        r_off      = r_addr_eff - ADDR_BASE;
        r_hit      = {1'b0, r_off} < SPAN;
        r_idx      = r_off[IDX_W+1:2];
        r_load     = ((r_state == R_IDLE) && arvalid_i && (lat == 8'd0)) ||
                     ((r_state == R_WAIT) && (r_cnt == 8'd1));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= R_IDLE;
            arready_o <= 1'b1;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            rresp_o   <= OKAY;
            r_addr_q  <= '0;
            r_cnt     <= '0;
        end else begin
            if (r_load) begin
                rdata_o <= r_hit ? mem[r_idx] : '0;
                rresp_o <= r_hit ? OKAY : SLVERR;
            end
            case (r_state)
                R_IDLE: if (arvalid_i) begin
                    r_addr_q  <= araddr_i;
                    arready_o <= 1'b0;
                    if (lat == 8'd0) begin
                        r_state  <= R_RESP;
                        rvalid_o <= 1'b1;
                    end else begin
                        r_state <= R_WAIT;
                        r_cnt   <= lat;
                    end
                end
                R_WAIT: if (r_cnt == 8'd1) begin
                    r_state  <= R_RESP;
                    rvalid_o <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
                R_RESP: if (rready_i) begin
                    r_state   <= R_IDLE;
                    rvalid_o  <= 1'b0;
                    arready_o <= 1'b1;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Commit uses the captured beat, or the live bus when that beat is accepted this cycle.
    always_comb begin
        aw_fire    = awready_o && awvalid_i;
        w_fire     = wready_o && wvalid_i;
        have_aw    = aw_got || aw_fire;
        have_w     = w_got || w_fire;
        w_addr_eff = aw_got ? aw_addr_q : awaddr_i;
        w_data_eff = w_got ? w_data_q : wdata_i;
        w_strb_eff = w_got ? w_strb_q : wstrb_i;
        w_off      = w_addr_eff - ADDR_BASE;
        w_hit      = {1'b0, w_off} < SPAN;
        w_idx      = w_off[IDX_W+1:2];
        w_commit   = rst_i &&
                     (((w_state == W_IDLE) && have_aw && have_w && (lat == 8'd0)) ||
                      ((w_state == W_WAIT) && (w_cnt == 8'd1)));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_state   <= W_IDLE;
            awready_o <= 1'b1;
            wready_o  <= 1'b1;
            bvalid_o  <= 1'b0;
            bresp_o   <= OKAY;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_cnt     <= '0;
        end else begin
            if (aw_fire) begin
                aw_got    <= 1'b1;
                aw_addr_q <= awaddr_i;
                awready_o <= 1'b0;
            end
            if (w_fire) begin
                w_got    <= 1'b1;
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
                wready_o <= 1'b0;
            end
            if (w_commit) bresp_o <= w_hit ? OKAY : SLVERR;
            case (w_state)
                W_IDLE: if (have_aw && have_w) begin
                    if (lat == 8'd0) begin
                        w_state  <= W_RESP;
                        bvalid_o <= 1'b1;
                    end else begin
                        w_state <= W_WAIT;
                        w_cnt   <= lat;
                    end
                end
                W_WAIT: if (w_cnt == 8'd1) begin
                    w_state  <= W_RESP;
                    bvalid_o <= 1'b1;
                end else begin
                    w_cnt <= w_cnt - 8'd1;
                end
                W_RESP: if (bready_i) begin
                    w_state   <= W_IDLE;
                    bvalid_o  <= 1'b0;
                    aw_got    <= 1'b0;
                    w_got     <= 1'b0;
                    awready_o <= 1'b1;
                    wready_o  <= 1'b1;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto plain SRAM; contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (w_commit && w_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_eff[b]) mem[w_idx][8*b +: 8] <= w_data_eff[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: a fixed-latency instance for directed vectors
// and an LFSR-latency instance for randomized traffic against a behavioural model.
module tb_axi_lite_sram;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;

    logic        fx_arready, fx_rvalid, fx_awready, fx_wready, fx_bvalid;
    logic        rn_arready, rn_rvalid, rn_awready, rn_wready, rn_bvalid;
    logic [31:0] fx_rdata, rn_rdata;
    logic [1:0]  fx_rresp, rn_rresp, fx_bresp, rn_bresp;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    assign arready = sel ? rn_arready : fx_arready;
    assign rvalid  = sel ? rn_rvalid  : fx_rvalid;
    assign awready = sel ? rn_awready : fx_awready;
    assign wready  = sel ? rn_wready  : fx_wready;
    assign bvalid  = sel ? rn_bvalid  : fx_bvalid;
    assign rdata   = sel ? rn_rdata   : fx_rdata;
    assign rresp   = sel ? rn_rresp   : fx_rresp;
    assign bresp   = sel ? rn_bresp   : fx_bresp;

    axi_lite_sram #(.LAT_MODE(0), .FIXED_LAT(2)) u_fix (
        .clk_i(clk), .rst_i(rst_n),
        .araddr_i(araddr), .arvalid_i(arvalid & ~sel), .arready_o(fx_arready),
        .rdata_o(fx_rdata), .rresp_o(fx_rresp), .rvalid_o(fx_rvalid), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid & ~sel), .awready_o(fx_awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid & ~sel), .wready_o(fx_wready),
        .bresp_o(fx_bresp), .bvalid_o(fx_bvalid), .bready_i(bready)
    );

    axi_lite_sram #(.LAT_MODE(1)) u_rnd (
        .clk_i(clk), .rst_i(rst_n),
        .araddr_i(araddr), .arvalid_i(arvalid & sel), .arready_o(rn_arready),
        .rdata_o(rn_rdata), .rresp_o(rn_rresp), .rvalid_o(rn_rvalid), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid & sel), .awready_o(rn_awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid & sel), .wready_o(rn_wready),
        .bresp_o(rn_bresp), .bvalid_o(rn_bvalid), .bready_i(bready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference LFSR from the polynomial x^8+x^6+x^5+x^4+1, advancing once per cycle.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic int exp_lat();
        return sel ? int'(m_lfsr & 8'h07) : 2;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    endfunction

    task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                           output logic [1:0] resp, output int lat, output int lat_exp,
                           output bit stable);
        int guard;
        stable = 1'b1; lat = 0; guard = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        while (!arready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        lat_exp = exp_lat();
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && lat < 64) begin
            lat++;
            @(negedge clk);
        end
        d = rdata; resp = rresp;
        repeat (hold) begin
            @(negedge clk);
            if (!rvalid || rdata !== d || rresp !== resp) stable = 1'b0;
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] st,
                            input int aw_dly, input int w_dly, output logic [1:0] resp,
                            output int lat, output int lat_exp, output bit rdy_ok);
        bit aw_done, w_done;
        int k;
        aw_done = 1'b0; w_done = 1'b0; k = 0; rdy_ok = 1'b1; lat = 0;
        awaddr = a; wdata = dat; wstrb = st;
        while (!(aw_done && w_done) && k < 64) begin
            @(negedge clk);
            if ((aw_done && awready) || (w_done && wready)) rdy_ok = 1'b0;
            awvalid = !aw_done && (k >= aw_dly);
            wvalid  = !w_done && (k >= w_dly);
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            k++;
        end
        lat_exp = exp_lat();
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && lat < 64) begin
            if (awready || wready) rdy_ok = 1'b0;
            lat++;
            @(negedge clk);
        end
        if (awready || wready) rdy_ok = 1'b0;
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        if (!awready || !wready) rdy_ok = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_arready"}, 32'(arready), 32'd1);
        check({tag, "_awready"}, 32'(awready), 32'd1);
        check({tag, "_wready"},  32'(wready),  32'd1);
        check({tag, "_rvalid"},  32'(rvalid),  32'd0);
        check({tag, "_bvalid"},  32'(bvalid),  32'd0);
        check({tag, "_rdata"},   rdata,        32'd0);
        check({tag, "_rresp"},   32'(rresp),   32'd0);
        check({tag, "_bresp"},   32'(bresp),   32'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[14];
        logic [31:0] d, v;
        logic [1:0]  resp;
        int          lat, le, k, w;
        bit          ok;
        logic [31:0] mdl[int];

        tbl[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        tbl[3]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'h5, 2'b00, 32'h0};
        tbl[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 2'b00, 32'hFF22_FF44};
        tbl[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};
        tbl[6]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
        tbl[7]  = '{1'b1, 32'h8000_4000, 32'h0BAD_BAD0, 4'hF, 2'b10, 32'h0};
        tbl[8]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        tbl[9]  = '{1'b1, 32'h8000_0012, 32'h0102_0304, 4'h0, 2'b00, 32'h0};
        tbl[10] = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        tbl[11] = '{1'b1, 32'h8000_3FFC, 32'hA5A5_5A5A, 4'hF, 2'b00, 32'h0};
        tbl[12] = '{1'b0, 32'h8000_3FFF, 32'h0,         4'h0, 2'b00, 32'hA5A5_5A5A};
        tbl[13] = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 2'b10, 32'h0};

        repeat (3) @(negedge clk);
        check_reset("rst_fix");
        sel = 1'b1;
        #1 check_reset("rst_rnd");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, resp, lat, le, ok);
                check($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(tbl[i].resp));
                check($sformatf("tbl%0d_blat", i), 32'(lat), 32'd2);
            end else begin
                do_read(tbl[i].addr, 0, d, resp, lat, le, ok);
                check($sformatf("tbl%0d_rresp", i), 32'(resp), 32'(tbl[i].resp));
                check($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
                check($sformatf("tbl%0d_rlat", i), 32'(lat), 32'd2);
            end
        end

        // AW before W, W before AW, and both together.
        for (int i = 0; i < 3; i++) begin
            int aw_d, w_d;
            aw_d = (i == 1) ? 4 : 0;
            w_d  = (i == 0) ? 4 : 0;
            do_write(32'h8000_0040, 32'h1000_0000 + 32'(i), 4'hF, aw_d, w_d, resp, lat, le, ok);
            check($sformatf("ord%0d_bresp", i), 32'(resp), 32'd0);
            check($sformatf("ord%0d_blat", i), 32'(lat), 32'd2);
            check($sformatf("ord%0d_ready_low", i), 32'(ok), 32'd1);
            do_read(32'h8000_0040, 0, d, resp, lat, le, ok);
            check($sformatf("ord%0d_rdata", i), d, 32'h1000_0000 + 32'(i));
        end

        do_read(32'h8000_0010, 5, d, resp, lat, le, ok);
        check("bp_stable", 32'(ok), 32'd1);
        check("bp_rdata", d, 32'hDEAD_BEEF);

        // Read and write to one word launched together commit in the same cycle.
        do_write(32'h8000_0080, 32'hAAAA_5555, 4'hF, 0, 0, resp, lat, le, ok);
        @(negedge clk);
        araddr = 32'h8000_0080; arvalid = 1'b1;
        awaddr = 32'h8000_0080; wdata = 32'h1234_ABCD; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        k = 0;
        while (!(rvalid && bvalid) && k < 16) begin
            @(negedge clk);
            k++;
        end
        check("conc_wait", 32'(k), 32'd2);
        check("conc_old_data", rdata, 32'hAAAA_5555);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        do_read(32'h8000_0080, 0, d, resp, lat, le, ok);
        check("conc_new_data", d, 32'h1234_ABCD);

        // Reset during W_WAIT drops the write.
        do_write(32'h8000_00C0, 32'h0F0F_0F0F, 4'hF, 0, 0, resp, lat, le, ok);
        @(negedge clk);
        awaddr = 32'h8000_00C0; wdata = 32'hF0F0_F0F0; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        rst_n = 1'b0;
        #1 check("rstw_bvalid", 32'(bvalid), 32'd0);
        check("rstw_awready", 32'(awready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstw_bvalid_after", 32'(bvalid), 32'd0);
        do_read(32'h8000_00C0, 0, d, resp, lat, le, ok);
        check("rstw_word_kept", d, 32'h0F0F_0F0F);

        // Reset while a read response is pending drops rvalid without a clock edge.
        @(negedge clk);
        araddr = 32'h8000_00C0; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("rstr_rvalid_pre", 32'(rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rstr_rvalid_async", 32'(rvalid), 32'd0);
        check("rstr_rdata_async", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic on the LFSR-latency instance.
        sel = 1'b1;
        for (int j = 0; j < 20; j++) begin
            logic [31:0] a;
            a = BASE + 32'(4 * ((j < 16) ? j : (DEPTH - 20 + j)));
            v = $urandom;
            do_write(a, v, 4'hF, 0, 0, resp, lat, le, ok);
            check($sformatf("init%0d_bresp", j), 32'(resp), 32'd0);
            check($sformatf("init%0d_lat", j), 32'(lat), 32'(le));
            mdl[int'((a - BASE) >> 2)] = v;
        end
        for (int t = 0; t < 1000; t++) begin
            logic [31:0] a;
            int r, j;
            r = $urandom_range(0, 9);
            j = $urandom_range(0, 19);
            if (r < 8)       a = BASE + 32'(4 * ((j < 16) ? j : (DEPTH - 20 + j)));
            else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 64));
            else             a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
            a = a + 32'($urandom_range(0, 3));
            w = int'((a - BASE) >> 2);
            if ($urandom_range(0, 1) == 1) begin
                logic [3:0] st;
                d  = $urandom;
                st = 4'($urandom_range(0, 15));
                do_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), resp, lat, le, ok);
                check($sformatf("rnd%0d_bresp", t), 32'(resp), addr_ok(a) ? 32'd0 : 32'd2);
                if (addr_ok(a)) begin
                    v = mdl[w];
                    for (int b = 0; b < 4; b++) if (st[b]) v[8*b +: 8] = d[8*b +: 8];
                    mdl[w] = v;
                end
            end else begin
                do_read(a, $urandom_range(0, 2), d, resp, lat, le, ok);
                check($sformatf("rnd%0d_rresp", t), 32'(resp), addr_ok(a) ? 32'd0 : 32'd2);
                check($sformatf("rnd%0d_rdata", t), d, addr_ok(a) ? mdl[w] : 32'd0);
            end
            check($sformatf("rnd%0d_lat", t), 32'(lat), 32'(le));
            check($sformatf("rnd%0d_lat_range", t), 32'(lat <= 7), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi_lite_sram.md
# axi_lite_sram

AXI4-Lite slave memory on the far side of the core's AXI-lite arbitrator; it serves instruction fetches and load/store traffic in the NPC simulation top. It holds a word-addressed SRAM array with byte-strobe writes and independent read and write channel FSMs. Each FSM allows one outstanding transaction. Response latency is fixed or pseudo-random, so the IFU/BDU/EXU/LSU handshakes are exercised under variable delay.

## Interface
- ADDR_BASE, 32'h8000_0000: byte address of word 0.
- DEPTH_WORDS, 4096: number of 32-bit words; power of two.
- LAT_MODE, 1: 0 = fixed latency FIXED_LAT; 1 = latency = lfsr & LAT_MASK.
- FIXED_LAT, 1: fixed extra latency in cycles, 0..255.
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.
- LAT_MASK, 8'h07: mask applied to the LFSR to form the random latency.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- araddr_i  in  32  read address.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- rdata_o  out  32  read data.
- rresp_o  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read data ready.
- awaddr_i  in  32  write address.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address ready.
- wdata_i  in  32  write data.
- wstrb_i  in  4  byte strobes; bit n enables byte n (wdata_i[8n+7:8n]).
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write data ready.
- bresp_o  out  2  write response: OKAY or SLVERR.
- bvalid_o  out  1  write response valid.
- bready_i  in  1  write response ready.

## Operation
- Address decode:
  - index = (addr - ADDR_BASE) >> 2; addr[1:0] is ignored.
  - An address is in range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS.
  - Out of range: response SLVERR; a read returns 0; a write leaves memory unchanged.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle from reset.
  - Read and write channels sample the same value when they start in the same cycle.
- Latency L is selected at transaction start: FIXED_LAT if LAT_MODE=0, else lfsr & LAT_MASK.
- Read FSM, states R_IDLE → R_WAIT → R_RESP:
  - R_IDLE: arready_o=1. On arvalid_i: latch the address and L; go to R_RESP if L=0, else R_WAIT with cnt=L.
  - R_WAIT: cnt decrements each cycle; when cnt=1, go to R_RESP.
  - On entry to R_RESP, register rdata_o/rresp_o from the array.
  - R_RESP: rvalid_o=1, and rdata_o/rresp_o are held stable until rready_i; then return to R_IDLE.
- Write FSM, states W_IDLE → W_WAIT → W_RESP:
  - W_IDLE: awready_o=1 until AW is captured; wready_o=1 until W is captured. AW and W may arrive in either order or in the same cycle.
  - When both are held: latch L; go to W_RESP if L=0, else W_WAIT, counting as in the read FSM.
  - On entry to W_RESP, the array write commits (bytes where wstrb_i bit is set, only if in range), and bresp_o is registered.
  - W_RESP: bvalid_o=1 until bready_i; then return to W_IDLE and clear the captured flags.
- wstrb=4'b0000 in range: no bytes change; bresp=OKAY.
- The array is not reset; contents are undefined until written.

## Timing
- Values during reset and after release:
  - arready_o=1, awready_o=1, wready_o=1.
  - rvalid_o=0, bvalid_o=0.
  - rdata_o=0, rresp_o=0, bresp_o=0.
  - LFSR=LFSR_SEED; both FSMs in IDLE with captured flags cleared.
- Read: AR handshake at cycle T → rvalid_o first high at T+1+L.
- Write: the later of the AW/W handshakes at cycle T → memory commit and bvalid_o first high at T+1+L.
- A response with ready already high completes in one cycle. The next address is accepted no earlier than the cycle after the response handshake.
- Read and write are fully concurrent.
- Read commit and write commit to the same word in the same cycle: the read returns the pre-write data.
- A read whose data register is loaded after a write commit returns the new data.
- Reset asserted mid-transaction:
  - Both FSMs go to IDLE immediately and valids drop asynchronously.
  - In-flight transactions are dropped; an uncommitted write never reaches the array.
  - Already-committed array data is retained.
- L=0 in LAT_MODE=1 is legal and gives minimum latency.

## Test plan
- Fixed latency: LAT_MODE=0, FIXED_LAT=2; write 32'hDEADBEEF to 0x8000_0010 with strobe 4'hF; read back the same address → bresp=00; rvalid exactly 3 cycles after AR handshake; rdata=DEADBEEF; rresp=00.
- Strobes: write 32'h11223344 with strobe 4'b0101 over word 0xFFFFFFFF → readback 32'hFF22FF44.
- AW/W ordering:
  - AW alone at cycle 0, W at cycle 4 → bvalid at 5+L; awready low from cycle 1 until the response handshake.
  - Repeat with W first, then with AW and W in the same cycle; same results.
- Out of range: read 0x7FFF_FFFC → rresp=10, rdata=0. Write to ADDR_BASE+4*DEPTH_WORDS → bresp=10; word 0 unchanged.
- Backpressure and concurrency:
  - Hold rready=0 for 5 cycles → rdata/rvalid stable throughout.
  - Simultaneous read and write to one word committing in the same cycle → read returns old data.
- Random latency and reset:
  - LAT_MODE=1, 1000 random transactions checked against a model; every latency is in 0..7.
  - Assert rst_i low during W_WAIT → bvalid=0 and the target word is unchanged.
